// File: rtl/interp_pkg.sv
// Shared types and helpers for the piecewise-linear interpolator:
// FSM state encoding, default Q formats and the output saturation function.
package interp_pkg;

  localparam int DEF_N  = 16;
  localparam int DEF_QN = 10;
  localparam int DEF_M  = 16;
  localparam int DEF_QM = 10;

  // Width of the intermediate sum y[k]+q before saturation.
  localparam int SW = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_FETCH,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  function automatic logic signed [SW-1:0] sat(input logic signed [SW-1:0] v, input int w);
    logic signed [SW-1:0] one;
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    one = 1;
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pwl_div.sv
// Sequential signed restoring divider: one quotient bit per cycle for DW cycles,
// operating on magnitudes and fixing the sign at the end (truncates toward zero).
module pwl_div #(
  parameter int DW = 34,
  parameter int VW = 17
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [DW-1:0] dividend,
  input  logic signed [VW-1:0] divisor,
  output logic signed [DW-1:0] quotient,
  output logic                 done
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] rem;
  logic [DW-1:0] quo;
  logic [VW-1:0] dvs;
  logic          neg;
  logic          busy;
  logic [CW-1:0] cnt;

  logic [DW-1:0] mag_a;
  logic [VW-1:0] mag_b;
  logic [DW:0]   rem_sh;
  logic [DW-1:0] sub;
  logic          ge;

  assign mag_a  = dividend[DW-1] ? DW'(~dividend + DW'(1)) : dividend;
  assign mag_b  = divisor[VW-1] ? VW'(~divisor + VW'(1)) : divisor;
  assign rem_sh = {rem, quo[DW-1]};
  assign ge     = rem_sh >= (DW + 1)'(dvs);
  // The remainder stays below the divisor, so the low DW bits hold the exact difference.
  assign sub    = rem_sh[DW-1:0] - DW'(dvs);

  // done marks the final iteration; the quotient is complete after that edge.
  assign done     = busy && (cnt == CW'(1));
  assign quotient = neg ? $signed(~quo + DW'(1)) : $signed(quo);

  always_ff @(posedge clock) begin
    if (reset) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      neg  <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      rem  <= '0;
      quo  <= mag_a;
      dvs  <= mag_b;
      neg  <= dividend[DW-1] ^ divisor[VW-1];
      busy <= 1'b1;
      cnt  <= CW'(DW);
    end else if (busy) begin
      rem  <= ge ? sub : rem_sh[DW-1:0];
      quo  <= {quo[DW-2:0], ge};
      cnt  <= cnt - CW'(1);
      busy <= (cnt != CW'(1));
    end
  end

endmodule

// File: rtl/interp_pwl.sv
// Piecewise-linear interpolator over a runtime-writable breakpoint LUT:
// binary search for the segment, exact interpolation via a sequential divider.
//
//  state    | meaning
//  S_IDLE   | ready; accepts LUT writes or a start
//  S_SEARCH | binary search, one index bit per cycle (AW cycles)
//  S_FETCH  | register dx, dy, t and range flags; pick clamp value
//  S_MUL    | form p = dy*t and launch the divider
//  S_DIV    | divider iterations (M+N+2 cycles)
//  S_DONE   | update y_out / out_of_range, pulse valid_out
module interp_pwl
  import interp_pkg::*;
#(
  parameter int    LUT_DEPTH = 16,
  parameter int    AW        = $clog2(LUT_DEPTH),
  parameter int    N         = DEF_N,
  parameter int    QN        = DEF_QN,
  parameter int    M         = DEF_M,
  parameter int    QM        = DEF_QM,
  parameter string LUT_INIT  = ""
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic signed [N-1:0] x_in,
  input  logic                clamp,
  output logic                ready,
  output logic                valid_out,
  output logic signed [M-1:0] y_out,
  output logic                out_of_range,
  input  logic                lut_we,
  input  logic [AW-1:0]       lut_addr,
  input  logic signed [N-1:0] lut_x,
  input  logic signed [M-1:0] lut_y
);

  localparam int PW = M + N + 2;

  if (LUT_DEPTH < 4 || (LUT_DEPTH & (LUT_DEPTH - 1)) != 0 || QN > N || QM > M) begin : g_bad_cfg
    $error("interp_pwl: unsupported LUT_DEPTH or Q format");
  end

  logic [N+M-1:0] lut_mem [LUT_DEPTH];

  state_t state, state_nx;

  logic signed [N-1:0]  xb;
  logic                 clamp_r;
  logic [AW-1:0]        k;
  logic [AW-1:0]        mask;
  logic signed [N:0]    dx;
  logic signed [N:0]    t;
  logic signed [M:0]    dy;
  logic signed [M-1:0]  yk;
  logic                 below;
  logic                 above;
  logic                 use_q;

  logic [AW-1:0]        cand;
  logic [AW-1:0]        kp1;
  logic signed [N-1:0]  x_cand, x_k, x_k1, x_0, x_last;
  logic signed [M-1:0]  y_k, y_k1, y_0, y_last;
  logic signed [N:0]    dx_w;
  logic                 below_w, above_w, clamp_hit, accept;
  logic signed [PW-1:0] p_w;
  logic signed [PW-1:0] quotient;
  logic signed [PW-1:0] q_eff;
  logic                 div_done;

  // Power-up contents; the array is deliberately outside reset.
  initial begin
    for (int i = 0; i < LUT_DEPTH; i++) lut_mem[i] = '0;
  end

  always @(posedge clock) begin
    if (lut_we && state == S_IDLE) lut_mem[lut_addr] <= {lut_x, lut_y};
  end

  assign cand   = k | mask;
  assign kp1    = k + AW'(1);
  assign x_cand = lut_mem[cand][N+M-1:M];
  assign x_k    = lut_mem[k][N+M-1:M];
  assign x_k1   = lut_mem[kp1][N+M-1:M];
  assign x_0    = lut_mem[0][N+M-1:M];
  assign x_last = lut_mem[LUT_DEPTH-1][N+M-1:M];
  assign y_k    = lut_mem[k][M-1:0];
  assign y_k1   = lut_mem[kp1][M-1:0];
  assign y_0    = lut_mem[0][M-1:0];
  assign y_last = lut_mem[LUT_DEPTH-1][M-1:0];

  assign ready     = (state == S_IDLE);
  assign accept    = start && !lut_we && ready;
  assign dx_w      = $signed({x_k1[N-1], x_k1}) - $signed({x_k[N-1], x_k});
  assign below_w   = xb < x_0;
  assign above_w   = xb > x_last;
  assign clamp_hit = clamp_r && (below_w || above_w);
  assign p_w       = PW'(dy) * PW'(t);
  assign q_eff     = use_q ? quotient : '0;

  // The divider's operand register is where p lives once MUL completes.
  pwl_div #(
    .DW(PW),
    .VW(N + 1)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (state == S_MUL),
    .dividend (p_w),
    .divisor  (dx),
    .quotient (quotient),
    .done     (div_done)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_SEARCH;
      S_SEARCH: if (mask[0]) state_nx = S_FETCH;
      S_FETCH:  state_nx = clamp_hit ? S_DONE : S_MUL;
      S_MUL:    state_nx = S_DIV;
      S_DIV:    if (div_done) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xb           <= '0;
      clamp_r      <= 1'b0;
      k            <= '0;
      mask         <= '0;
      dx           <= '0;
      dy           <= '0;
      t            <= '0;
      yk           <= '0;
      below        <= 1'b0;
      above        <= 1'b0;
      use_q        <= 1'b0;
      y_out        <= '0;
      out_of_range <= 1'b0;
      valid_out    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            xb      <= x_in;
            clamp_r <= clamp;
            k       <= '0;
            mask    <= {1'b1, {(AW-1){1'b0}}};
          end
        end
        S_SEARCH: begin
          // Index LUT_DEPTH-1 can never start a segment.
          if (cand <= AW'(LUT_DEPTH - 2) && x_cand <= xb) k <= cand;
          mask <= mask >> 1;
        end
        S_FETCH: begin
          dx    <= dx_w;
          dy    <= $signed({y_k1[M-1], y_k1}) - $signed({y_k[M-1], y_k});
          t     <= $signed({xb[N-1], xb}) - $signed({x_k[N-1], x_k});
          below <= below_w;
          above <= above_w;
          yk    <= clamp_hit ? (below_w ? y_0 : y_last) : y_k;
          use_q <= !clamp_hit && !dx_w[N] && (dx_w != '0);
        end
        S_DONE: begin
          y_out        <= M'(sat(SW'(yk) + SW'(q_eff), M));
          out_of_range <= below || above;
          valid_out    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_pwl.sv
// Randomized scoreboard bench for interp_pwl against an arithmetic reference model.
module tb_interp_pwl;

  localparam int D     = 16;
  localparam int AW    = 4;
  localparam int N     = 16;
  localparam int M     = 16;
  localparam int Q     = M + N + 2;
  localparam int LAT_I = AW + Q + 3;
  localparam int LAT_C = AW + 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                clamp = 1'b0;
  logic                lut_we = 1'b0;
  logic signed [N-1:0] x_in = '0;
  logic signed [N-1:0] lut_x = '0;
  logic signed [M-1:0] lut_y = '0;
  logic [AW-1:0]       lut_addr = '0;
  logic                ready;
  logic                valid_out;
  logic signed [M-1:0] y_out;
  logic                out_of_range;

  interp_pwl dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .x_in         (x_in),
    .clamp        (clamp),
    .ready        (ready),
    .valid_out    (valid_out),
    .y_out        (y_out),
    .out_of_range (out_of_range),
    .lut_we       (lut_we),
    .lut_addr     (lut_addr),
    .lut_x        (lut_x),
    .lut_y        (lut_y)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int y;
    bit oor;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   xs[D];
  int   ys[D];
  int   exp_last = 0;
  bit   started = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: largest segment start not above x, plain integer arithmetic.
  function automatic void model(input int xv, input bit cl, output int ye, output bit oe);
    int     k;
    longint dxl, dyl, tl, ql, sl;
    k = 0;
    for (int i = 0; i < D - 1; i++) if (xs[i] <= xv) k = i;
    oe = (xv < xs[0]) || (xv > xs[D-1]);
    if (oe && cl) begin
      ye = (xv < xs[0]) ? ys[0] : ys[D-1];
    end else begin
      dxl = longint'(xs[k+1]) - longint'(xs[k]);
      dyl = longint'(ys[k+1]) - longint'(ys[k]);
      tl  = longint'(xv) - longint'(xs[k]);
      ql  = (dxl > 0) ? (dyl * tl) / dxl : 0;
      sl  = longint'(ys[k]) + ql;
      if (sl > 32767) sl = 32767;
      else if (sl < -32768) sl = -32768;
      ye = int'(sl);
    end
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (started && !reset) begin
      if (valid_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", int'(valid_out), 0);
        end else begin
          e = sb.pop_front();
          chk("y_out", int'(y_out), e.y);
          chk("out_of_range", int'(out_of_range), int'(e.oor));
          chk("valid_cycle", cyc, e.cyc);
          exp_last = e.y;
        end
      end else begin
        chk("y_out_hold", int'(y_out), exp_last);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", int'(ready), 1);
  endtask

  task automatic calc(input int xv, input bit cl);
    int ye;
    bit oe;
    wait_ready();
    model(xv, cl, ye, oe);
    start = 1'b1;
    x_in  = N'(xv);
    clamp = cl;
    @(posedge clock);
    #1;
    sb.push_back('{ye, oe, cyc + ((oe && cl) ? LAT_C : LAT_I)});
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", int'(ready), 0);
  endtask

  task automatic lut_write(input int a, input int xv, input int yv);
    wait_ready();
    lut_we   = 1'b1;
    lut_addr = AW'(a);
    lut_x    = N'(xv);
    lut_y    = M'(yv);
    @(negedge clock);
    lut_we = 1'b0;
    xs[a]  = xv;
    ys[a]  = yv;
  endtask

  int dir_x[10] = '{2560, 3072, 15360, -1024, -1024, 32767, 32767, -32768, 0, 1000};
  bit dir_c[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int               n;
    int               xv;
    logic signed [15:0] r16;

    for (int i = 0; i < D; i++) begin
      xs[i] = 0;
      ys[i] = 0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("reset_ready", int'(ready), 1);
    chk("reset_valid", int'(valid_out), 0);
    chk("reset_y_out", int'(y_out), 0);
    chk("reset_oor", int'(out_of_range), 0);
    started = 1'b1;

    for (int i = 0; i < D; i++) lut_write(i, 1024 * i, 2048 * i);
    for (int i = 0; i < 10; i++) calc(dir_x[i], dir_c[i]);

    // Modified breakpoint.
    lut_write(3, 3072, 0);
    calc(2560, 1'b0);

    // Write and start together: write wins, no calculation.
    wait_ready();
    lut_we   = 1'b1;
    lut_addr = AW'(3);
    lut_x    = N'(3072);
    lut_y    = M'(6144);
    start    = 1'b1;
    x_in     = N'(2560);
    clamp    = 1'b0;
    @(negedge clock);
    lut_we = 1'b0;
    start  = 1'b0;
    xs[3]  = 3072;
    ys[3]  = 6144;
    chk("collide_ready", int'(ready), 1);
    calc(2560, 1'b0);

    // Write while busy must be dropped.
    calc(1000, 1'b0);
    lut_we   = 1'b1;
    lut_addr = AW'(1);
    lut_x    = N'(1024);
    lut_y    = M'(9999);
    @(negedge clock);
    lut_we = 1'b0;
    calc(1536, 1'b0);

    // Reset in the middle of the divide.
    calc(2560, 1'b0);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
    exp_last = 0;
    @(negedge clock);
    chk("midrst_ready", int'(ready), 1);
    chk("midrst_y_out", int'(y_out), 0);
    chk("midrst_valid", int'(valid_out), 0);
    chk("midrst_oor", int'(out_of_range), 0);
    calc(2560, 1'b0);

    // Random ascending table and random samples.
    xv = -32768 + int'($urandom_range(0, 4000));
    for (int i = 0; i < D; i++) begin
      r16 = 16'($urandom);
      lut_write(i, xv, int'(r16));
      xv = xv + int'($urandom_range(1, 4000));
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        xv = xs[0] + int'($urandom_range(0, 32'(xs[D-1] - xs[0])));
      end else begin
        r16 = 16'($urandom);
        xv  = int'(r16);
      end
      calc(xv, 1'($urandom_range(0, 1)));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
